// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier: radix-2 by default, radix-4 modified Booth when BOOTH_RADIX4_EN is defined.
// States: S_IDLE | waiting for start ; S_RUN | one Booth step per cycle ; S_DONE | product valid, done pulse
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Operands are always extended to the widest E (WIDTH+2); only the iteration count and the
    // product extraction point depend on mode, since the extended value is the same number.
    localparam int QW    = WIDTH + 2;
    localparam int AW    = WIDTH + 4;
    localparam int PW    = AW + QW + 1;
    localparam int CW    = $clog2(WIDTH + 2);
    localparam int OFF_S = 3;
`ifdef BOOTH_RADIX4_EN
    localparam int N_S   = WIDTH / 2;
    localparam int N_U   = WIDTH / 2 + 1;
    localparam int OFF_U = 1;
    localparam int SHIFT = 2;
`else
    localparam int N_S   = WIDTH;
    localparam int N_U   = WIDTH + 1;
    localparam int OFF_U = 2;
    localparam int SHIFT = 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [QW-1:0]        r_m;
    logic                 r_signed;
    logic [PW-1:0]        r_p;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;
    logic                 w_accept;
    logic [AW-1:0]        w_m_ext;
    logic [AW-1:0]        w_addend;
    logic [AW-1:0]        w_acc_sum;
    logic [PW-1:0]        w_p_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [QW-1:0]        w_q_ext;

    assign w_m_ext = {{(AW-QW){r_m[QW-1]}}, r_m};
    assign w_q_ext = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};

    always_comb begin
        w_addend = '0;
`ifdef BOOTH_RADIX4_EN
        case (r_p[2:0])
            3'b001, 3'b010: w_addend = w_m_ext;
            3'b011:         w_addend = w_m_ext << 1;
            3'b100:         w_addend = -(w_m_ext << 1);
            3'b101, 3'b110: w_addend = -w_m_ext;
            default:        w_addend = '0;
        endcase
`else
        case (r_p[1:0])
            2'b01:   w_addend = w_m_ext;
            2'b10:   w_addend = -w_m_ext;
            default: w_addend = '0;
        endcase
`endif
        w_acc_sum = r_p[PW-1 -: AW] + w_addend;
        w_p_next  = $signed({w_acc_sum, r_p[PW-AW-1:0]}) >>> SHIFT;
        // After N steps the low product bits sit just above the unconsumed multiplier extension bits
        w_prod    = r_signed ? w_p_next[OFF_S +: 2*WIDTH] : w_p_next[OFF_U +: 2*WIDTH];
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = start;
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == '0) w_state_next = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                w_accept = start;
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_signed  <= 1'b0;
            r_p       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_signed <= signed_mode;
                r_m      <= signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                        : {2'b00, multiplicand};
                r_p      <= {{AW{1'b0}}, w_q_ext, 1'b0};
                r_cnt    <= signed_mode ? CW'(N_S - 1) : CW'(N_U - 1);
            end else if (r_state == S_RUN) begin
                r_p   <= w_p_next;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == '0) r_product <= w_prod;
            end
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Randomized self-checking bench for booth_mult_seq against a plain-arithmetic product model.
module tb_booth_mult_seq;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   mc;
    logic [W-1:0]   mp;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [63:0]    model_prod;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (mc),
        .multiplier   (mp),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Cycle (counted from the accepting edge) in which done is expected
    function automatic int exp_lat(input bit sgn);
`ifdef BOOTH_RADIX4_EN
        return sgn ? W/2 + 1 : W/2 + 2;
`else
        return sgn ? W + 1 : W + 2;
`endif
    endfunction

    // Called right after a negedge; returns at the negedge of the done cycle
    task automatic op(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                      input bit mid_start);
        int lat, nbusy, unstable, busy_at_done;
        start = 1'b1; signed_mode = sgn; mc = a; mp = b;
        @(posedge clk);
        #1;
        start = 1'b0; signed_mode = 1'($urandom_range(1, 0)); mc = $urandom; mp = $urandom;
        lat = 0; nbusy = 0; unstable = 0; busy_at_done = 1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                busy_at_done = int'(busy);
                break;
            end
            if (busy) nbusy++;
            if (product !== model_prod) unstable++;
            if (mid_start && c == 4) begin
                start = 1'b1; signed_mode = ~sgn; mc = $urandom; mp = $urandom;
            end else if (mid_start && c == 5) begin
                start = 1'b0;
            end
        end
        model_prod = ref_mul(sgn, a, b);
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat(sgn)));
        chk({tag, " busy_cycles"}, 64'(nbusy), 64'(exp_lat(sgn) - 1));
        chk({tag, " busy_in_done"}, 64'(busy_at_done), 64'd0);
        chk({tag, " product_hold"}, 64'(unstable), 64'd0);
        chk({tag, " product"}, product, model_prod);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, " done_low"}, 64'(done), 64'd0);
        chk({tag, " busy_low"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int extra;
        bit sgn, b2b, mid;
        logic [31:0] a, b;
        logic [31:0] edge_vals [6];
        edge_vals = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0001};

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; mc = '0; mp = '0;
        model_prod = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset product", product, 64'd0);

        start = 1'b1; signed_mode = 1'b1; mc = 32'd9; mp = 32'd9;
        @(negedge clk);
        chk("rst_over_start busy", 64'(busy), 64'd0);
        rst = 1'b0; start = 1'b0;
        idle_check("rst_over_start");

        op("neg7x3", 1'b1, 32'hFFFF_FFF9, 32'd3, 1'b0);
        chk("neg7x3 literal", product, 64'hFFFF_FFFF_FFFF_FFEB);
        idle_check("neg7x3");

        op("min_x_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("min_x_min literal", product, 64'h4000_0000_0000_0000);
        idle_check("min_x_min");

        op("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("umax literal", product, 64'hFFFF_FFFE_0000_0001);
        idle_check("umax");

        op("mid_start", 1'b1, 32'd1234, 32'hFFFF_E9D2, 1'b1);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("mid_start extra_done", 64'(extra), 64'd0);
        chk("mid_start product_kept", product, model_prod);

        op("b2b_first", 1'b1, 32'd11, 32'd13, 1'b0);
        op("b2b_second", 1'b1, 32'd5, 32'd6, 1'b0);
        chk("b2b_second literal", product, 64'd30);
        idle_check("b2b");

        start = 1'b1; signed_mode = 1'b1; mc = 32'd99; mp = 32'd77;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_prod = '0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort product", product, 64'd0);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("abort no_done", 64'(extra), 64'd0);
        op("after_abort", 1'b1, 32'd12, 32'd12, 1'b0);
        chk("after_abort literal", product, 64'd144);
        idle_check("after_abort");

        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(1, 0));
            a = ($urandom_range(3, 0) == 0) ? edge_vals[$urandom_range(5, 0)] : $urandom;
            b = ($urandom_range(3, 0) == 0) ? edge_vals[$urandom_range(5, 0)] : $urandom;
            mid = ($urandom_range(4, 0) == 0);
            b2b = 1'($urandom_range(1, 0));
            op($sformatf("rand%0d", i), sgn, a, b, mid);
            if (!b2b) idle_check($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 Parameter WIDTH, default 32; operand width; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request; sampled only when the block can accept.
REQ-005 signed_mode  input  1  1 = two's-complement operands; 0 = unsigned operands; captured with start.
REQ-006 multiplicand  input  WIDTH  operand M; captured with start.
REQ-007 multiplier  input  WIDTH  operand Q; captured with start.
REQ-008 busy  output  1  high while an iteration sequence runs.
REQ-009 done  output  1  one-cycle pulse; product valid.
REQ-010 product  output  2*WIDTH  result; held until the next accepted start or reset.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE.
- IDLE/DONE + start -> RUN.
- RUN -> DONE after N iterations.
- DONE -> IDLE if start is low.
REQ-012 start SHALL be accepted in IDLE or DONE, so back-to-back operations are supported; start during RUN SHALL be ignored and SHALL NOT disturb the operation in flight.
REQ-013 On acceptance, the block SHALL capture M, Q and signed_mode.
- Operands SHALL be extended to E bits by sign extension (signed_mode=1) or zero extension (signed_mode=0).
- Accumulator SHALL clear; Q(-1) SHALL be 0.
REQ-014 Radix-2 mode: each RUN cycle SHALL perform one Booth step.
- Pair {Q0,Q-1} = 01 adds M; 10 subtracts M; 00/11 adds nothing.
- The step SHALL end with an arithmetic right shift of {acc,Q,Q-1}.
REQ-015 Radix-2 mode: E = WIDTH for signed, WIDTH+1 for unsigned; N = E iterations.
REQ-016 Internal accumulator SHALL be E+2 bits wide so that no intermediate overflow occurs; 0x8000... operands SHALL be handled exactly.
REQ-017 Latency: start sampled at edge k.
- busy SHALL be high for cycles k+1..k+N.
- done and a valid product SHALL appear in cycle k+N+1; busy SHALL be low in that cycle.
REQ-018 product SHALL equal the exact 2*WIDTH-bit result.
- Signed mode: two's-complement result.
- Unsigned mode: unsigned result.
- Low 2*WIDTH bits SHALL be taken; no truncation is needed because the result always fits.
REQ-019 product SHALL update only in the cycle done asserts; it SHALL remain stable during RUN.
REQ-020 Operand inputs SHALL be don't-care except in the start acceptance cycle.

Reset
REQ-021 When rst is high at a clock edge:
- state SHALL go to IDLE;
- busy=0, done=0, product=0;
- internal registers SHALL clear.
REQ-022 rst SHALL override start in the same cycle.
REQ-023 Reset during RUN SHALL abort the operation with no done pulse; the next start after rst deasserts SHALL behave as a fresh operation.

Configuration
REQ-024 Macro BOOTH_RADIX4_EN.
- Defined: radix-4 modified Booth recoding on {Q1,Q0,Q-1}, with digits {-2M,-M,0,+M,+2M} and a 2-bit arithmetic shift per step. E = WIDTH+2 for unsigned, WIDTH for signed. N = WIDTH/2 (signed) or WIDTH/2+1 (unsigned).
- Undefined: radix-2 per REQ-014/015.
- Interface, handshake and results SHALL be identical in both builds; only N differs.

Verification (WIDTH=32; radix-2 latencies given, radix-4 per REQ-024)
REQ-025 Signed -7 x 3 -> done at k+33; product=0xFFFFFFFF_FFFFFFEB.
REQ-026 Signed 0x80000000 x 0x80000000 -> product=0x40000000_00000000.
REQ-027 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> done at k+34; product=0xFFFFFFFE_00000001.
REQ-028 start pulsed mid-RUN with different operands -> first result unchanged; exactly one done.
REQ-029 start held high in the DONE cycle with new operands (5 x 6 signed) -> second done delivers 30; no idle gap.
REQ-030 rst asserted at iteration 10 -> busy=0, product=0, no done; a following 12 x 12 operation yields 144.
